// File: rtl/topk_stream_sorter_pkg.sv
// Shared types for the top-K stream sorter: FSM states, slot record and the ordering compare.
`timescale 1ns/1ps
package topk_pkg;

  localparam int TOPK_WIDTH = 32;

  typedef enum logic [0:0] {
    S_ACCEPT = 1'b0,
    S_DRAIN  = 1'b1
  } topk_state_t;

  typedef struct packed {
    logic [TOPK_WIDTH-1:0] value;
    logic [TOPK_WIDTH-1:0] index;
    logic                  occ;
  } topk_slot_t;

  // Strict compare so an incoming equal value never displaces an earlier one.
  function automatic logic beats(input logic asce,
                                 input logic [TOPK_WIDTH-1:0] a,
                                 input logic [TOPK_WIDTH-1:0] b);
    return asce ? (a < b) : (a > b);
  endfunction

endpackage

// File: rtl/topk_stream_sorter_if.sv
// Stream bundle for the top-K sorter: control, input pair stream, sorted output stream, occupancy.
`timescale 1ns/1ps
interface topk_stream_sorter_if #(
  parameter int WIDTH = 32,
  parameter int K     = 20
);
  localparam int CNT_W = $clog2(K + 1);

  // Both streams: a beat transfers on the rising edge where valid && ready are
  // both high; the source holds payload stable while valid && !ready.
  logic             clear;
  logic             asce;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [WIDTH-1:0] in_index;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [WIDTH-1:0] out_index;
  logic [CNT_W-1:0] out_rank;
  logic             out_last;
  logic [CNT_W-1:0] count;

  modport master (
    output clear, asce, in_valid, in_data, in_index, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_index, out_rank, out_last, count
  );

  modport slave (
    input  clear, asce, in_valid, in_data, in_index, in_last, out_ready,
    output in_ready, out_valid, out_data, out_index, out_rank, out_last, count
  );
endinterface

// File: rtl/topk_slot.sv
// One insertion-array slot: takes the new pair, shifts in its left neighbour, or holds.
// Index register exists only when TOPK_INDEX_EN is defined.
`timescale 1ns/1ps
module topk_slot
  import topk_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  load_en,
  input  logic                  mode_asce,
  input  logic [TOPK_WIDTH-1:0] in_value,
  input  logic [TOPK_WIDTH-1:0] in_index,
  input  logic                  beat_prev,
  input  topk_slot_t            left,
  output logic                  beat,
  output topk_slot_t            slot
);

  logic [TOPK_WIDTH-1:0] value_q;
  logic                  occ_q;
  logic [TOPK_WIDTH-1:0] index_val;

  assign beat = !occ_q || beats(mode_asce, in_value, value_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
      occ_q   <= 1'b0;
    end else if (flush) begin
      occ_q <= 1'b0;
    end else if (load_en) begin
      if (beat_prev) begin
        value_q <= left.value;
        occ_q   <= left.occ;
      end else if (beat) begin
        value_q <= in_value;
        occ_q   <= 1'b1;
      end
    end
  end

`ifdef TOPK_INDEX_EN
  logic [TOPK_WIDTH-1:0] index_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index_q <= '0;
    end else if (load_en && !flush) begin
      if (beat_prev) begin
        index_q <= left.index;
      end else if (beat) begin
        index_q <= in_index;
      end
    end
  end

  assign index_val = index_q;
`else
  logic unused_index;
  assign unused_index = ^{in_index, left.index};
  assign index_val    = '0;
`endif

  assign slot = '{value: value_q, index: index_val, occ: occ_q};

endmodule

// File: rtl/topk_stream_sorter.sv
// Top-K selector: accepts (value, index) pairs, keeps the K best in a sorted insertion
// array, then drains them best-first. TOPK_INDEX_EN builds index storage.
`timescale 1ns/1ps
module topk_stream_sorter
  import topk_pkg::*;
#(
  parameter int WIDTH = TOPK_WIDTH,
  parameter int K     = 20
)(
  input  logic                  clk,
  input  logic                  rst_n,
  topk_stream_sorter_if.slave   bus,
  output topk_state_t           dbg_state
);

  localparam int CNT_W = $clog2(K + 1);

  topk_state_t      state_q, state_d;
  logic [CNT_W-1:0] count_q, rank_q, last_rank;
  logic             mode_q, mode_eff;
  logic             in_ready, out_valid;
  logic             accept, load_en, out_hs, drain_done, flush;
  logic [K-1:0]     beat;
  topk_slot_t       slots [K];
  logic [WIDTH-1:0] sel_value, sel_index;

  assign in_ready   = (state_q == S_ACCEPT);
  assign out_valid  = (state_q == S_DRAIN);
  assign last_rank  = count_q - CNT_W'(1);
  assign accept     = bus.in_valid && in_ready;
  assign load_en    = accept && !bus.clear;
  assign out_hs     = out_valid && bus.out_ready;
  assign drain_done = out_hs && (rank_q == last_rank);
  assign flush      = bus.clear || drain_done;
  // The first pair of a stream sees the live asce; later pairs use the latched mode.
  assign mode_eff   = (count_q == '0) ? bus.asce : mode_q;

  for (genvar i = 0; i < K; i++) begin : g_slot
    topk_slot_t left;
    logic       beat_prev;
    if (i == 0) begin : g_head
      assign left      = '0;
      assign beat_prev = 1'b0;
    end else begin : g_body
      assign left      = slots[i-1];
      assign beat_prev = beat[i-1];
    end

    topk_slot u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .load_en   (load_en),
      .mode_asce (mode_eff),
      .in_value  (bus.in_data),
      .in_index  (bus.in_index),
      .beat_prev (beat_prev),
      .left      (left),
      .beat      (beat[i]),
      .slot      (slots[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_ACCEPT;
      count_q <= '0;
      rank_q  <= '0;
      mode_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      if (flush) begin
        count_q <= '0;
        rank_q  <= '0;
      end else begin
        if (load_en && count_q != CNT_W'(K)) count_q <= count_q + CNT_W'(1);
        if (out_hs) rank_q <= rank_q + CNT_W'(1);
      end
      if (load_en && count_q == '0) mode_q <= bus.asce;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_ACCEPT: if (accept && bus.in_last) state_d = S_DRAIN;
      S_DRAIN:  if (drain_done) state_d = S_ACCEPT;
      default:  state_d = S_ACCEPT;
    endcase
    if (bus.clear) state_d = S_ACCEPT;
  end

  always_comb begin
    sel_value = '0;
    sel_index = '0;
    for (int i = 0; i < K; i++) begin
      if (rank_q == CNT_W'(i)) begin
        sel_value = slots[i].value;
        sel_index = slots[i].index;
      end
    end
  end

  // Only the last slot's beat and occupancy have no downstream consumer.
  logic unused_tail;
  assign unused_tail = beat[K-1] ^ slots[K-1].occ;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_valid ? sel_value : '0;
  assign bus.out_rank  = out_valid ? rank_q : '0;
  assign bus.out_last  = out_valid && (rank_q == last_rank);
  assign bus.count     = count_q;
`ifdef TOPK_INDEX_EN
  assign bus.out_index = out_valid ? sel_index : '0;
`else
  logic unused_sel_index;
  assign unused_sel_index = ^sel_index;
  assign bus.out_index    = '0;
`endif
  assign dbg_state = state_q;

endmodule

// File: tb/tb_topk_stream_sorter.sv
// Self-checking bench for topk_stream_sorter (K=4): directed streams, stalls, clear, reset, random streams.
`timescale 1ns/1ps
module tb_topk_stream_sorter;
  import topk_pkg::*;

  localparam int W     = 32;
  localparam int K     = 4;
  localparam int CNT_W = $clog2(K + 1);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  topk_state_t dbg_state;

  topk_stream_sorter_if #(.WIDTH(W), .K(K)) bus ();

  topk_stream_sorter #(.WIDTH(W), .K(K)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0]     exp_q[$];
  logic [W-1:0]     exp_idx_q[$];
  logic [CNT_W-1:0] exp_rank_q[$];
  logic             exp_last_q[$];
  logic [W-1:0]     stim_v[$];
  logic [W-1:0]     stim_i[$];

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic flush_expect();
    exp_q.delete();
    exp_idx_q.delete();
    exp_rank_q.delete();
    exp_last_q.delete();
  endtask

  // Reference: stable sort of the whole stream, then keep the first K.
  task automatic push_model(input bit mode);
    logic [W-1:0] sv[$];
    logic [W-1:0] si[$];
    int n;
    for (int i = 0; i < stim_v.size(); i++) begin
      int pos;
      pos = sv.size();
      for (int j = 0; j < sv.size(); j++) begin
        if (pos == sv.size() && (mode ? (sv[j] > stim_v[i]) : (sv[j] < stim_v[i]))) pos = j;
      end
      sv.insert(pos, stim_v[i]);
      si.insert(pos, stim_i[i]);
    end
    n = (sv.size() < K) ? sv.size() : K;
    for (int r = 0; r < n; r++) begin
      exp_q.push_back(sv[r]);
`ifdef TOPK_INDEX_EN
      exp_idx_q.push_back(si[r]);
`else
      exp_idx_q.push_back('0);
`endif
      exp_rank_q.push_back(CNT_W'(r));
      exp_last_q.push_back(r == n - 1);
    end
  endtask

  task automatic drive_stream(input bit mode);
    int n;
    n = stim_v.size();
    push_model(mode);
    for (int i = 0; i < n; i++) begin
      int c;
      c = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = stim_v[i];
      bus.in_index = stim_i[i];
      bus.in_last  = (i == n - 1);
      bus.asce     = (i == 0) ? mode : ~mode;
      while (!bus.in_ready && c < 50) begin
        @(posedge clk); #1;
        c++;
      end
      if (c >= 50) check("in_ready_wait", W'(bus.in_ready), W'(1));
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check("count_after_stream", W'(bus.count), W'((n < K) ? n : K));
    check("state_drain", W'(dbg_state), W'(S_DRAIN));
  endtask

  task automatic run_drain(input logic [3:0] pat);
    int c;
    int p;
    c = 0;
    p = 0;
    while (exp_q.size() > 0 && c < 100) begin
      bus.out_ready = pat[p % 4];
      p++;
      @(posedge clk); #1;
      c++;
    end
    bus.out_ready = 1'b0;
    check("drain_remaining", W'(exp_q.size()), W'(0));
    check("post_drain_valid", W'(bus.out_valid), W'(0));
    check("post_drain_count", W'(bus.count), W'(0));
    check("post_drain_ready", W'(bus.in_ready), W'(1));
  endtask

  // Output monitor: compares each drained entry and checks hold-stability during stalls.
  logic             stall_prev = 1'b0;
  logic [W-1:0]     hold_d, hold_i;
  logic [CNT_W-1:0] hold_r;

  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      check("in_ready_in_drain", W'(bus.in_ready), W'(0));
      if (stall_prev) begin
        check("hold_data", bus.out_data, hold_d);
        check("hold_index", bus.out_index, hold_i);
        check("hold_rank", W'(bus.out_rank), W'(hold_r));
      end
      if (bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_output", W'(exp_q.size()), W'(1));
        end else begin
          check("out_data", bus.out_data, exp_q.pop_front());
          check("out_index", bus.out_index, exp_idx_q.pop_front());
          check("out_rank", W'(bus.out_rank), W'(exp_rank_q.pop_front()));
          check("out_last", W'(bus.out_last), W'(exp_last_q.pop_front()));
        end
        stall_prev = 1'b0;
      end else begin
        stall_prev = 1'b1;
        hold_d = bus.out_data;
        hold_i = bus.out_index;
        hold_r = bus.out_rank;
      end
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"}, W'(bus.in_ready), W'(1));
    check({tag, "_out_valid"}, W'(bus.out_valid), W'(0));
    check({tag, "_out_last"}, W'(bus.out_last), W'(0));
    check({tag, "_out_rank"}, W'(bus.out_rank), W'(0));
    check({tag, "_out_data"}, bus.out_data, W'(0));
    check({tag, "_out_index"}, bus.out_index, W'(0));
    check({tag, "_count"}, W'(bus.count), W'(0));
  endtask

  initial begin
    bus.clear     = 1'b0;
    bus.asce      = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_index  = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    #12;
    check_idle("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Ascending, overflow drops the worst
    stim_v = '{7, 3, 9, 1, 5};
    stim_i = '{100, 101, 102, 103, 104};
    drive_stream(1'b1);
    run_drain(4'b1111);

    // Descending with stable ties, smallest dropped
    stim_v = '{2, 8, 8, 8, 1};
    stim_i = '{0, 1, 5, 9, 4};
    drive_stream(1'b0);
    run_drain(4'b1111);

    // Short stream
    stim_v = '{6, 4};
    stim_i = '{11, 12};
    drive_stream(1'b1);
    run_drain(4'b1111);

    // Downstream stalls with ready 1,0,0,1
    stim_v = '{40, 10, 30, 20, 50};
    stim_i = '{1, 2, 3, 4, 5};
    drive_stream(1'b1);
    run_drain(4'b1001);

    // clear on the second drain handshake
    stim_v = '{20, 30, 40, 50};
    stim_i = '{0, 1, 2, 3};
    drive_stream(1'b1);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.clear = 1'b1;
    @(posedge clk); #1;
    bus.clear     = 1'b0;
    bus.out_ready = 1'b0;
    flush_expect();
    check_idle("after_clear");
    stim_v = '{10};
    stim_i = '{77};
    drive_stream(1'b1);
    run_drain(4'b1111);

    // Asynchronous reset mid-drain
    stim_v = '{7, 3, 9, 1, 5};
    stim_i = '{100, 101, 102, 103, 104};
    drive_stream(1'b1);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("async_reset");
    check("async_reset_state", W'(dbg_state), W'(S_ACCEPT));
    flush_expect();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    drive_stream(1'b1);
    run_drain(4'b1111);

    // Random streams with small values to force ties
    for (int s = 0; s < 6; s++) begin
      int len;
      bit mode;
      logic [3:0] pat;
      len  = $urandom_range(1, 7);
      mode = 1'($urandom_range(0, 1));
      pat  = 4'($urandom_range(0, 15)) | 4'b0001;
      stim_v.delete();
      stim_i.delete();
      for (int i = 0; i < len; i++) begin
        stim_v.push_back(W'($urandom_range(0, 15)));
        stim_i.push_back(W'($urandom_range(0, 1000)));
      end
      drive_stream(mode);
      run_drain(pat);
    end

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
